// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: state encoding, core address map and byte-lane helpers shared by
// the aes_seq_ctrl sequencer.
package aes_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_DATA = 3'd1,
    ST_LOAD_KEY  = 3'd2,
    ST_RUN       = 3'd3,
    ST_READ      = 3'd4,
    ST_RESP      = 3'd5
  } aes_state_e;

  localparam int AES_BYTES  = 16;
  localparam int BLK_W      = 128;
  localparam int BYTE_IDX_W = 4;
  localparam int ADDR_W     = 5;

  localparam logic [ADDR_W-1:0] AES_DATA_BASE = 5'd0;
  localparam logic [ADDR_W-1:0] AES_KEY_BASE  = 5'd16;

  // Byte k of a block occupies bits [127-8k -: 8]; this returns the lane LSB.
  function automatic logic [6:0] byte_lsb(input logic [BYTE_IDX_W-1:0] idx);
    return 7'd120 - {idx, 3'b000};
  endfunction

  function automatic logic [7:0] byte_sel(input logic [BLK_W-1:0] blk,
                                          input logic [BYTE_IDX_W-1:0] idx);
    return blk[byte_lsb(idx) +: 8];
  endfunction

endpackage

// File: rtl/aes_seq_ctrl.sv
// aes_seq_ctrl: drives the byte-serial AES-128 core from a 128-bit request/response
// stream. Define AES_KEY_CACHE_EN to skip reloading an unchanged key.
module aes_seq_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int READ_LAT       = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_decrypt,
  input  logic [127:0] req_block,
  input  logic [127:0] req_key,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_block,
  output logic         rsp_err,
  output logic [4:0]   aes_addr,
  output logic [7:0]   aes_data_in,
  output logic         aes_wr_en,
  output logic         aes_start,
  output logic         aes_decrypt,
  input  logic [7:0]   aes_data_out,
  input  logic         aes_busy,
  input  logic         aes_done
);

  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int BC_W = $clog2(AES_BYTES + READ_LAT + 1);

  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BC_W-1:0] LOAD_LAST = BC_W'(AES_BYTES - 1);
  localparam logic [BC_W-1:0] READ_LAST = BC_W'(AES_BYTES + READ_LAT - 1);
  localparam logic [BC_W-1:0] RD_FIRST  = BC_W'(READ_LAT);
  localparam logic [BC_W-1:0] BYTES_B   = BC_W'(AES_BYTES);

  aes_state_e            state_r, state_s;
  logic [BC_W-1:0]       byte_cnt_r;
  logic [TO_W-1:0]       to_cnt_r;
  logic [127:0]          block_r, key_r, rsp_block_r;
  logic                  dec_r, rsp_err_r;
  logic [BYTE_IDX_W-1:0] byte_idx_s, rd_idx_s;
  logic                  load_last_s, timeout_s, key_hit_s, busy_unused_s;

  assign byte_idx_s    = byte_cnt_r[BYTE_IDX_W-1:0];
  assign rd_idx_s      = byte_idx_s - BYTE_IDX_W'(READ_LAT);
  assign load_last_s   = (byte_cnt_r == LOAD_LAST);
  assign timeout_s     = (state_r == ST_RUN) && !aes_done && (to_cnt_r == TO_LAST);
  assign busy_unused_s = aes_busy;
  assign rsp_block     = rsp_block_r;
  assign rsp_err       = rsp_err_r;

`ifdef AES_KEY_CACHE_EN
  logic [127:0] key_cache_r;
  logic         key_cache_vld_r;

  assign key_hit_s = key_cache_vld_r && (key_cache_r == key_r);

  // Remember the key the core holds; a timeout leaves the core state unknown.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_cache_r     <= '0;
      key_cache_vld_r <= 1'b0;
    end else if (timeout_s) begin
      key_cache_vld_r <= 1'b0;
    end else if (state_r == ST_LOAD_KEY && load_last_s) begin
      key_cache_r     <= key_r;
      key_cache_vld_r <= 1'b1;
    end else begin
      key_cache_r     <= key_cache_r;
      key_cache_vld_r <= key_cache_vld_r;
    end
  end
`else
  assign key_hit_s = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:      if (req_valid) state_s = ST_LOAD_DATA; else state_s = ST_IDLE;
      ST_LOAD_DATA: if (load_last_s) state_s = key_hit_s ? ST_RUN : ST_LOAD_KEY;
                    else state_s = ST_LOAD_DATA;
      ST_LOAD_KEY:  if (load_last_s) state_s = ST_RUN; else state_s = ST_LOAD_KEY;
      ST_RUN:       if (aes_done) state_s = ST_READ;
                    else if (timeout_s) state_s = ST_RESP;
                    else state_s = ST_RUN;
      ST_READ:      if (byte_cnt_r == READ_LAST) state_s = ST_RESP; else state_s = ST_READ;
      ST_RESP:      if (rsp_ready) state_s = ST_IDLE; else state_s = ST_RESP;
      default:      state_s = ST_IDLE;
    endcase
  end

  // State, counters, request latch and result assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      byte_cnt_r  <= '0;
      to_cnt_r    <= '0;
      block_r     <= '0;
      key_r       <= '0;
      dec_r       <= 1'b0;
      rsp_block_r <= '0;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      // Byte counter restarts on every state change so each phase counts from 0.
      if (state_s != state_r) byte_cnt_r <= '0;
      else byte_cnt_r <= byte_cnt_r + BC_W'(1);
      if (state_r == ST_RUN) to_cnt_r <= to_cnt_r + TO_W'(1);
      else to_cnt_r <= '0;

      if (state_r == ST_IDLE && req_valid) begin
        block_r     <= req_block;
        key_r       <= req_key;
        dec_r       <= req_decrypt;
        rsp_block_r <= '0;
        rsp_err_r   <= 1'b0;
      end else if (timeout_s) begin
        rsp_block_r <= '0;
        rsp_err_r   <= 1'b1;
      end else if (state_r == ST_READ && byte_cnt_r >= RD_FIRST) begin
        rsp_block_r[byte_lsb(rd_idx_s) +: 8] <= aes_data_out;
      end
    end
  end

  // Output decode, driven purely from registered state.
  always_comb begin
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    aes_addr    = 5'd0;
    aes_data_in = 8'd0;
    aes_wr_en   = 1'b0;
    aes_start   = 1'b0;
    aes_decrypt = 1'b0;
    case (state_r)
      ST_IDLE: req_ready = 1'b1;
      ST_LOAD_DATA: begin
        aes_wr_en   = 1'b1;
        aes_addr    = AES_DATA_BASE + {1'b0, byte_idx_s};
        aes_data_in = byte_sel(block_r, byte_idx_s);
        aes_decrypt = dec_r;
      end
      ST_LOAD_KEY: begin
        aes_wr_en   = 1'b1;
        aes_addr    = AES_KEY_BASE + {1'b0, byte_idx_s};
        aes_data_in = byte_sel(key_r, byte_idx_s);
        aes_decrypt = dec_r;
      end
      ST_RUN: begin
        aes_start   = 1'b1;
        aes_decrypt = dec_r;
      end
      ST_READ: begin
        aes_start   = 1'b1;
        aes_decrypt = dec_r;
        // Trailing READ_LAT cycles only wait for data; park on the last byte.
        if (byte_cnt_r < BYTES_B) aes_addr = AES_DATA_BASE + {1'b0, byte_idx_s};
        else aes_addr = AES_DATA_BASE + 5'd15;
      end
      ST_RESP: rsp_valid = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// tb_aes_seq_ctrl: bench for aes_seq_ctrl with a behavioural byte-serial core and a
// block-level reference model; follows AES_KEY_CACHE_EN when defined.
module tb_aes_seq_ctrl;

  localparam int TO = 64;
`ifdef AES_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam logic [127:0] NIST_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] NIST_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] NIST_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst, req_valid, req_ready, req_decrypt, rsp_valid, rsp_ready, rsp_err;
  logic [127:0] req_block, req_key, rsp_block;
  logic [4:0]   aes_addr;
  logic [7:0]   aes_data_in, aes_data_out;
  logic         aes_wr_en, aes_start, aes_decrypt, aes_busy, aes_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  aes_seq_ctrl #(.TIMEOUT_CYCLES(TO), .READ_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_decrypt(req_decrypt),
    .req_block(req_block), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_block(rsp_block), .rsp_err(rsp_err),
    .aes_addr(aes_addr), .aes_data_in(aes_data_in), .aes_wr_en(aes_wr_en),
    .aes_start(aes_start), .aes_decrypt(aes_decrypt), .aes_data_out(aes_data_out),
    .aes_busy(aes_busy), .aes_done(aes_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural core: NIST vectors for the known key, a simple keyed mix otherwise.
  function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k,
                                           input logic dec);
    logic [127:0] t;
    if (k == NIST_KEY && !dec && d == NIST_PT) return NIST_CT;
    if (k == NIST_KEY && dec && d == NIST_CT) return NIST_PT;
    t = d ^ {k[63:0], k[127:64]};
    if (dec) return ~t;
    return {t[119:0], t[127:120]};
  endfunction

  logic [7:0]   mem [32];
  logic [127:0] res_r = '0;
  int           run_cnt = 0;
  logic         core_done = 1'b0;
  int           core_delay = 4;
  bit           never_done = 1'b0;
  bit           done_force = 1'b0;

  function automatic logic [127:0] mem_blk(input int base);
    logic [127:0] b = '0;
    for (int k = 0; k < 16; k++) b = {b[119:0], mem[base + k]};
    return b;
  endfunction

  always @(posedge clk) begin
    if (aes_wr_en === 1'b1) mem[aes_addr] <= aes_data_in;
    aes_data_out <= 8'(res_r >> (8 * (15 - int'(aes_addr[3:0]))));
    if (aes_start !== 1'b1) begin
      run_cnt   <= 0;
      core_done <= 1'b0;
    end else begin
      if (run_cnt == 0) res_r <= core_fn(mem_blk(0), mem_blk(16), aes_decrypt);
      run_cnt   <= run_cnt + 1;
      core_done <= !never_done && (run_cnt + 1 >= core_delay);
    end
  end
  assign aes_done = core_done | done_force;
  assign aes_busy = aes_start & ~aes_done;

  typedef struct { int c; logic [4:0] a; logic [7:0] d; } wr_t;
  wr_t  wr_q[$];
  int   start_q[$];
  logic start_d = 1'b0;

  always @(negedge clk) begin
    if (aes_wr_en === 1'b1) wr_q.push_back('{c: cyc, a: aes_addr, d: aes_data_in});
    if (aes_start === 1'b1 && !start_d) start_q.push_back(cyc);
    start_d <= (aes_start === 1'b1);
  end

  // Reference key-cache state, kept at block level.
  bit           mc_vld = 1'b0;
  logic [127:0] mc_key = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic do_request(input logic [127:0] blk, input logic [127:0] key, input logic dec,
                            input int bp, input bit to_exp, input string tag);
    logic [127:0] exp_blk, held;
    logic [7:0]   exp_d;
    bit           key_load;
    int           wbase, sbase, acc, n, bad, nexp, start_c, rsp_c;
    exp_blk  = to_exp ? 128'd0 : core_fn(blk, key, dec);
    key_load = !(CACHE && mc_vld && mc_key == key);
    nexp     = key_load ? 32 : 16;
    wbase    = wr_q.size();
    sbase    = start_q.size();
    @(negedge clk);
    req_block = blk; req_key = key; req_decrypt = dec; req_valid = 1'b1;
    acc = cyc;
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0; req_block = '0; req_key = '0; req_decrypt = 1'b0;
    chk({tag, "_ready_drop"}, req_ready, 1'b0);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rsp_seen"}, rsp_valid, 1'b1);
    rsp_c   = cyc;
    start_c = (start_q.size() > sbase) ? start_q[sbase] : -1000;
    chk({tag, "_rsp_block"}, rsp_block, exp_blk);
    chk({tag, "_rsp_err"}, rsp_err, to_exp);
    chk({tag, "_start_off_in_resp"}, aes_start, 1'b0);
    chk({tag, "_start_latency"}, start_c - acc, key_load ? 33 : 17);
    if (to_exp) chk({tag, "_timeout_latency"}, rsp_c - start_c, TO);
    if (done_force) chk({tag, "_early_done_latency"}, rsp_c - start_c, 18);
    chk({tag, "_wr_count"}, wr_q.size() - wbase, nexp);
    bad = 0;
    for (int i = 0; i < nexp && wbase + i < wr_q.size(); i++) begin
      exp_d = (i < 16) ? 8'(blk >> (8 * (15 - i))) : 8'(key >> (8 * (31 - i)));
      if (wr_q[wbase + i].a !== 5'(i) || wr_q[wbase + i].d !== exp_d ||
          wr_q[wbase + i].c != acc + 1 + i) bad++;
    end
    chk({tag, "_wr_log"}, bad, 0);
    held = rsp_block;
    bad = 0;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_block !== held || req_ready !== 1'b0 ||
          rsp_err !== to_exp) bad++;
    end
    if (bp > 0) chk({tag, "_backpressure_hold"}, bad, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_idle_ready"}, req_ready, 1'b1);
    chk({tag, "_valid_drop"}, rsp_valid, 1'b0);
    if (key_load) begin
      mc_vld = 1'b1;
      mc_key = key;
    end
    if (to_exp) mc_vld = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    logic [127:0] rk, rb, prev_key;
    int n;
    bit bad;
    rst = 1'b1; req_valid = 1'b0; req_decrypt = 1'b0; req_block = '0; req_key = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {req_ready, rsp_valid, rsp_err, aes_wr_en, aes_start, aes_decrypt,
                       aes_addr, aes_data_in}, {1'b1, 18'd0});
    chk("reset_block", rsp_block, 128'd0);
    rst = 1'b0;

    core_delay = 5;
    do_request(NIST_PT, NIST_KEY, 1'b0, 0, 1'b0, "nist_enc");
    core_delay = 3;
    do_request(NIST_CT, NIST_KEY, 1'b1, 5, 1'b0, "nist_dec_bp");

    done_force = 1'b1;
    do_request({$urandom, $urandom, $urandom, $urandom}, NIST_KEY, 1'b0, 0, 1'b0, "early_done");
    done_force = 1'b0;

    prev_key = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 6; i++) begin
      rk = (i % 2 == 1) ? prev_key : {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      prev_key = rk;
      core_delay = $urandom_range(1, 20);
      do_request(rb, rk, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, "random");
    end

    never_done = 1'b1;
    do_request(NIST_PT, prev_key, 1'b0, 2, 1'b1, "timeout");
    never_done = 1'b0;
    core_delay = 2;
    do_request(NIST_CT, prev_key, 1'b1, 0, 1'b0, "after_timeout");

    // Abort in the middle of the key load (key byte 7 = core address 23).
    @(negedge clk);
    req_block = {$urandom, $urandom, $urandom, $urandom};
    req_key = {$urandom, $urandom, $urandom, $urandom};
    req_decrypt = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!(aes_wr_en === 1'b1 && aes_addr === 5'd23) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reached", aes_addr, 5'd23);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ctrl", {req_ready, rsp_valid, rsp_err, aes_wr_en, aes_start, aes_decrypt,
                         aes_addr, aes_data_in}, {1'b1, 18'd0});
    chk("rst_mid_block", rsp_block, 128'd0);
    mc_vld = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
    end
    chk("rst_mid_no_rsp", bad, 1'b0);
    core_delay = 6;
    do_request(NIST_PT, NIST_KEY, 1'b0, 0, 1'b0, "post_reset_nist");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
